// File: rtl/lfsr_period_checker.sv
// Measures the period of an LFSR after each seed load and flags lock-up,
// timeout and a misplaced lfsr_done pulse.
//
// state | meaning
// IDLE  | waiting for the first seed load
// ARM   | seed loading; captures lfsr_data on the first edge with load_seed low
// COUNT | counting clocks until lfsr_data returns to the captured value
// DONE  | period result valid and held
// ERROR | lock-up or timeout seen; flags held
module lfsr_period_checker #(
    parameter int N          = 4,
    parameter int CHECK_DONE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_seed,
    input  logic [N-1:0] lfsr_data,
    input  logic         lfsr_done,
    output logic         busy,
    output logic         result_valid,
    output logic [N:0]   period,
    output logic         maximal,
    output logic         lockup_err,
    output logic         timeout_err,
    output logic         done_mismatch
);

    typedef enum logic [2:0] {IDLE, ARM, COUNT, DONE, ERROR} state_t;

    localparam logic [N:0] CNT_MAX    = (N+1)'(1) << N;
    localparam logic [N:0] PERIOD_MAX = CNT_MAX - (N+1)'(1);

    state_t       state_q, state_d;
    logic [N-1:0] ref_q, ref_d;
    logic [N:0]   cnt_q, cnt_d;
    logic [N:0]   period_q, period_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         maximal_q, maximal_d;
    logic         lockup_q, lockup_d;
    logic         timeout_q, timeout_d;
    logic         dmis_q, dmis_d;
    logic         match;

    assign match = (lfsr_data == ref_q);

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = valid_q;
        lockup_d  = lockup_q;
        timeout_d = timeout_q;
        dmis_d    = dmis_q;

        if (load_seed) begin
            state_d   = ARM;
            cnt_d     = '0;
            period_d  = '0;
            valid_d   = 1'b0;
            lockup_d  = 1'b0;
            timeout_d = 1'b0;
            dmis_d    = 1'b0;
        end else begin
            case (state_q)
                ARM: begin
                    ref_d = lfsr_data;
                    cnt_d = (N+1)'(1);
                    if (lfsr_data == '0) begin
                        lockup_d = 1'b1;
                        state_d  = ERROR;
                    end else begin
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    // lfsr_done must be high exactly on the wrap edge
                    if (CHECK_DONE != 0 && (lfsr_done != match))
                        dmis_d = 1'b1;
                    if (lfsr_data == '0) begin
                        lockup_d = 1'b1;
                        state_d  = ERROR;
                    end else if (match) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ERROR;
                    end else begin
                        cnt_d = cnt_q + (N+1)'(1);
                    end
                end
                default: ;
            endcase
        end

        busy_d    = (state_d == ARM) || (state_d == COUNT);
        maximal_d = valid_d && (period_d == PERIOD_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ref_q     <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            maximal_q <= 1'b0;
            lockup_q  <= 1'b0;
            timeout_q <= 1'b0;
            dmis_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            maximal_q <= maximal_d;
            lockup_q  <= lockup_d;
            timeout_q <= timeout_d;
            dmis_q    <= dmis_d;
        end
    end

    assign busy          = busy_q;
    assign result_valid  = valid_q;
    assign period        = period_q;
    assign maximal       = maximal_q;
    assign lockup_err    = lockup_q;
    assign timeout_err   = timeout_q;
    assign done_mismatch = dmis_q;

endmodule
